// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-clock divider plus horizontal/vertical counters for 640x480@60.
// Generates sync, blanking, pixel coordinates and a frame-start strobe for the colour/zone stage.
// Optional macro VGA_TIMING_PIPE_EN adds a one-pixel delay stage on hs/vs/blank_n/frame_start.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       clockVGA,
  output logic       pix_en,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
);

  localparam int unsigned CW      = 10;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;

  logic [DIV_W-1:0] div;
  logic [CW-1:0]    h_cnt;
  logic [CW-1:0]    v_cnt;
  logic             last_pix;
  logic             last_line;
  logic             frame_wrap;
  logic             hs_r;
  logic             vs_r;
  logic             blank_r;
  logic             fs_r;

  assign pix_en    = (div == DIV_W'(CLK_DIV - 1));
  assign last_pix  = (h_cnt == CW'(H_TOTAL - 1));
  assign last_line = (v_cnt == CW'(V_TOTAL - 1));

  // System-clock divider: counts 0..CLK_DIV-1, pix_en marks the last slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div <= '0;
    else if (pix_en) div <= '0;
    else div <= div + DIV_W'(1);
  end

  // Pixel clock to the DAC: high for the upper half of the divider period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) clockVGA <= 1'b0;
    else clockVGA <= (div >= DIV_W'(CLK_DIV / 2));
  end

  // Horizontal and vertical counters, advanced once per pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (last_pix) begin
        h_cnt <= '0;
        v_cnt <= last_line ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  // Remembers that the counters just wrapped (799,524)->(0,0) so the strobe lines up with x/y.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_wrap <= 1'b0;
    else frame_wrap <= pix_en && last_pix && last_line;
  end

  // Registered decodes of the current counters, one clk behind them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_r    <= 1'b1;
      vs_r    <= 1'b1;
      blank_r <= 1'b0;
      fs_r    <= 1'b0;
      x       <= '0;
      y       <= '0;
    end else begin
      hs_r    <= !((h_cnt >= CW'(HS_BEG)) && (h_cnt < CW'(HS_END)));
      vs_r    <= !((v_cnt >= CW'(VS_BEG)) && (v_cnt < CW'(VS_END)));
      blank_r <= (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
      fs_r    <= frame_wrap;
      x       <= h_cnt;
      y       <= v_cnt;
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  logic pix_load;
  logic hs_q;
  logic vs_q;
  logic blank_q;
  logic fs_q;
  logic fs_pend;

  // Decodes refresh on the clk right after pix_en; loading the stage there gives exactly one pixel of delay.
  assign pix_load = (div == '0);

  // One-pixel delay stage; frame_start is held pending until the next load so it stays one clk wide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      fs_pend <= 1'b0;
    end else begin
      if (pix_load) begin
        hs_q    <= hs_r;
        vs_q    <= vs_r;
        blank_q <= blank_r;
      end
      fs_q <= pix_load && fs_pend;
      if (fs_r) fs_pend <= 1'b1;
      else if (pix_load) fs_pend <= 1'b0;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_q;
  assign frame_start = fs_q;
`else
  assign vga_hs      = hs_r;
  assign vga_vs      = vs_r;
  assign vga_blank_n = blank_r;
  assign frame_start = fs_r;
`endif

endmodule
